bitrev_reorder_buf: RTL and testbench

//  Streaming bit-reversal reorder buffer for the R2SDF FFT output. Accepts one sample/cycle
//  in pipeline (bit-reversed-index) order and emits it in natural order, or passes it

---
 rtl/bitrev_pkg.sv | 28 ++
 rtl/bitrev_reorder_buf_idx.sv | 14 +
 rtl/bitrev_reorder_buf.sv | 152 +++++++++++++++
 tb/tb_bitrev_reorder_buf.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitrev_pkg.sv
// Shared helpers for the bit-reversal reorder buffer: frame sizing and index reversal.
package bitrev_pkg;

   localparam int LOG2N_DEF = 3;

   function automatic int npts(input int log2n);
      return 1 << log2n;
   endfunction

   function automatic int cnt_w(input int log2n);
      return $clog2(log2n + 1);
   endfunction

   // Reverses the low nbits of idx; bits at and above nbits come back as zero.
   function automatic logic [31:0] rev_bits(input logic [31:0] idx, input int nbits);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < nbits) r[i] = idx[nbits-1-i];
      end
      return r;
   endfunction

   function automatic logic [31:0] len_mask(input int nbits);
      return (32'd1 << nbits) - 32'd1;
   endfunction

endpackage

// File: rtl/bitrev_reorder_buf_idx.sv
// Combinational read-address reverser; only the low nbits_i bits take part.
module bitrev_idx
   import bitrev_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF
) (
   input  logic [LOG2N-1:0]        idx_i,
   input  logic [cnt_w(LOG2N)-1:0] nbits_i,
   output logic [LOG2N-1:0]        idx_o
);

   assign idx_o = LOG2N'(rev_bits(32'(idx_i), int'(nbits_i)));

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong bit-reversal reorder buffer: output starts 1 cycle after a frame completes, 1 sample/cycle.
// in_ready drops only when both banks are full; VAR_SIZE_EN adds per-frame length via cfg_log2n.
module bitrev_reorder_buf
   import bitrev_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bypass,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_sof,
   output logic          out_eof
`ifdef VAR_SIZE_EN
   ,
   input  logic [cnt_w(LOG2N)-1:0] cfg_log2n
`endif
);

   localparam int NPTS = npts(LOG2N);
   localparam int CW   = cnt_w(LOG2N);

   logic [DW-1:0]    bank_q [2][NPTS];
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [LOG2N-1:0] rev_cnt, rd_addr;
   logic             bypass_q, bypass_d;
   logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [CW-1:0]    wr_n, rd_n;
   logic             wr_fire, wr_last, rd_load, rd_last;

`ifdef VAR_SIZE_EN
   logic [CW-1:0] len_q [2];
   logic [CW-1:0] cfg_n;

   assign cfg_n = (cfg_log2n == '0 || int'(cfg_log2n) > LOG2N) ? CW'(LOG2N) : cfg_log2n;
   // The length is latched with index 0, so the first write of a frame must use cfg_n directly.
   assign wr_n  = (wr_cnt_q == '0) ? cfg_n : len_q[wr_bank_q];
   assign rd_n  = len_q[rd_bank_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q[0] <= CW'(LOG2N);
         len_q[1] <= CW'(LOG2N);
      end else if (wr_fire && wr_cnt_q == '0) begin
         len_q[wr_bank_q] <= cfg_n;
      end
   end
`else
   assign wr_n = CW'(LOG2N);
   assign rd_n = CW'(LOG2N);
`endif

   assign in_ready = !rst && !full_q[wr_bank_q];
   assign wr_fire  = in_valid && in_ready;
   assign wr_last  = (wr_cnt_q == LOG2N'(len_mask(int'(wr_n))));
   assign rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);
   assign rd_last  = (rd_cnt_q == LOG2N'(len_mask(int'(rd_n))));

   bitrev_idx #(.LOG2N(LOG2N)) u_rev (
      .idx_i   (rd_cnt_q),
      .nbits_i (rd_n),
      .idx_o   (rev_cnt)
   );

   // Index 0 reverses to itself, so the bypass value latched at sof never affects the first read.
   assign rd_addr = bypass_q ? rd_cnt_q : rev_cnt;

   always_comb begin
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      bypass_d    = bypass_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;

      if (wr_fire) begin
         if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_cnt_d          = '0;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
         end
      end

      if (rd_load) begin
         out_valid_d = 1'b1;
         out_data_d  = bank_q[rd_bank_q][rd_addr];
         out_sof_d   = (rd_cnt_q == '0);
         out_eof_d   = rd_last;
         if (rd_cnt_q == '0) bypass_d = bypass;
         if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_cnt_d          = '0;
            rd_bank_d         = ~rd_bank_q;
         end else begin
            rd_cnt_d = rd_cnt_q + LOG2N'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         bypass_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         bypass_q    <= bypass_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) bank_q[wr_bank_q][wr_cnt_q] <= in_data;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed bench for bitrev_reorder_buf (LOG2N=3, DW=32); define VAR_SIZE_EN to cover cfg_log2n.
module tb_bitrev_reorder_buf;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst, bypass, in_valid, in_ready, out_valid, out_ready, out_sof, out_eof;
   logic [DW-1:0] in_data, out_data;
`ifdef VAR_SIZE_EN
   logic [1:0]    cfg_log2n;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int stalls = 0;

   logic [31:0] q_dat [$];
   logic        q_sof [$];
   logic        q_eof [$];
   int          q_cyc [$];

   typedef struct {
      logic             byp;
      logic [7:0][31:0] din;
      logic [7:0][31:0] dout;
   } vec_t;

   vec_t vecs [3];
   int   ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   logic [31:0] pat_in  [8] = '{32'hDEAD0000, 32'h11, 32'h22, 32'hFFFFFFFF,
                                32'h0, 32'h5A5A5A5A, 32'h7, 32'h80000000};
   logic [31:0] pat_out [8] = '{32'hDEAD0000, 32'h0, 32'h22, 32'h7,
                                32'h11, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h80000000};

   bitrev_reorder_buf #(.LOG2N(3), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bypass    (bypass),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sof   (out_sof),
      .out_eof   (out_eof)
`ifdef VAR_SIZE_EN
      ,
      .cfg_log2n (cfg_log2n)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every output handshake; values are stable at the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         q_dat.push_back(out_data);
         q_sof.push_back(out_sof);
         q_eof.push_back(out_eof);
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired or data missing", name);
   endtask

   task automatic clr();
      q_dat.delete();
      q_sof.delete();
      q_eof.delete();
      q_cyc.delete();
   endtask

   task automatic push(input logic [31:0] d);
      logic ok;
      int   n;
      n        = 0;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && n <= 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (!ok) begin
            stalls++;
            n++;
         end
      end
      if (!ok) fail_now("push_timeout");
      in_valid = 1'b0;
   endtask

   task automatic wait_outs(input string name, input int n);
      int k;
      k = 0;
      while (q_dat.size() < n && k < 200) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk({name, "_count"}, q_dat.size(), n);
   endtask

   task automatic chk_out(input string name, input int idx, input logic [31:0] exp_d,
                          input logic exp_sof, input logic exp_eof);
      if (idx >= q_dat.size()) begin
         fail_now($sformatf("%s_missing%0d", name, idx));
      end else begin
         chk($sformatf("%s_data%0d", name, idx), q_dat[idx], exp_d);
         chk($sformatf("%s_flags%0d", name, idx), {q_sof[idx], q_eof[idx]}, {exp_sof, exp_eof});
      end
   endtask

   task automatic chk_frame(input string name, input int off, input logic [7:0][31:0] exp);
      for (int i = 0; i < 8; i++) chk_out(name, off + i, exp[i], i == 0, i == 7);
   endtask

   initial begin
      logic [7:0][31:0] exp;
      int first_rdy, first_eof, gaps;

      rst       = 1'b1;
      bypass    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
`ifdef VAR_SIZE_EN
      cfg_log2n = 2'd3;
`endif

      for (int i = 0; i < 8; i++) begin
         vecs[0].din[i]  = 32'(i);
         vecs[0].dout[i] = 32'(ord[i]);
         vecs[1].din[i]  = 32'(10 + i);
         vecs[1].dout[i] = 32'(10 + i);
         vecs[2].din[i]  = pat_in[i];
         vecs[2].dout[i] = pat_out[i];
      end
      vecs[0].byp = 1'b0;
      vecs[1].byp = 1'b1;
      vecs[2].byp = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sof_eof", {out_sof, out_eof}, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Single frames from the table, each checking the 1-cycle output latency
      for (int v = 0; v < 3; v++) begin
         clr();
         bypass = vecs[v].byp;
         for (int i = 0; i < 8; i++) push(vecs[v].din[i]);
         chk($sformatf("v%0d_lat_pre", v), out_valid, 0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_lat_post", v), out_valid, 1);
         wait_outs($sformatf("v%0d", v), 8);
         chk_frame($sformatf("v%0d", v), 0, vecs[v].dout);
      end
      bypass = 1'b0;

      // Three frames back to back: no input stalls, no output gaps
      clr();
      stalls = 0;
      for (int i = 0; i < 24; i++) push(32'(i));
      wait_outs("b2b", 24);
      chk("b2b_stalls", stalls, 0);
      gaps = 0;
      for (int i = 1; i < q_cyc.size(); i++) if (q_cyc[i] != q_cyc[i-1] + 1) gaps++;
      chk("b2b_gaps", gaps, 0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) exp[i] = 32'(8 * k + ord[i]);
         chk_frame($sformatf("b2b_f%0d", k), 8 * k, exp);
      end

      // Sink stalled: both banks fill, output holds sample 0
      clr();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(32'(i));
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      chk("full_out_data", out_data, 0);
      chk("full_out_sof", out_sof, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("hold_out_data", out_data, 0);
      chk("hold_valid_sof", {out_valid, out_sof, out_eof}, 3'b110);
      chk("hold_in_ready", in_ready, 0);
      out_ready = 1'b1;
      first_rdy = -1;
      first_eof = -1;
      for (int k = 0; k < 40 && (first_rdy < 0 || first_eof < 0); k++) begin
         @(negedge clk);
         if (first_rdy < 0 && in_ready) first_rdy = cyc;
         if (first_eof < 0 && out_valid && out_eof) first_eof = cyc;
      end
      chk("drain_eof_seen", first_eof >= 0, 1);
      chk("drain_rdy_cycle", first_rdy, first_eof);
      for (int i = 16; i < 21; i++) push(32'(i));
      wait_outs("drain", 16);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) exp[i] = 32'(8 * k + ord[i]);
         chk_frame($sformatf("drain_f%0d", k), 8 * k, exp);
      end

      // Reset with a partial frame buffered
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_out", {31'(out_valid), out_sof, out_eof}, 0);
      chk("mid_rst_data", out_data, 0);
      rst = 1'b0;
      clr();
      for (int i = 0; i < 8; i++) push(32'(100 + i));
      wait_outs("after_rst", 8);
      for (int i = 0; i < 8; i++) exp[i] = 32'(100 + ord[i]);
      chk_frame("after_rst", 0, exp);
      repeat (10) @(posedge clk);
      #1;
      chk("after_rst_no_extra", q_dat.size(), 8);

      // Bypass changed mid-frame keeps the frame's order; next frame reverses again
      clr();
      bypass = 1'b1;
      for (int i = 0; i < 8; i++) push(32'(40 + i));
      @(posedge clk);
      #1;
      bypass = 1'b0;
      for (int i = 0; i < 8; i++) push(32'(50 + i));
      wait_outs("byp_tog", 16);
      for (int i = 0; i < 8; i++) exp[i] = 32'(40 + i);
      chk_frame("byp_tog_f0", 0, exp);
      for (int i = 0; i < 8; i++) exp[i] = 32'(50 + ord[i]);
      chk_frame("byp_tog_f1", 8, exp);

`ifdef VAR_SIZE_EN
      // 4-point frame, then 8-point, then a clamped length of 0
      clr();
      cfg_log2n = 2'd2;
      for (int i = 0; i < 4; i++) push(32'(i));
      wait_outs("var4", 4);
      chk_out("var4", 0, 32'd0, 1'b1, 1'b0);
      chk_out("var4", 1, 32'd2, 1'b0, 1'b0);
      chk_out("var4", 2, 32'd1, 1'b0, 1'b0);
      chk_out("var4", 3, 32'd3, 1'b0, 1'b1);
      clr();
      cfg_log2n = 2'd3;
      for (int i = 0; i < 8; i++) push(32'(60 + i));
      wait_outs("var8", 8);
      for (int i = 0; i < 8; i++) exp[i] = 32'(60 + ord[i]);
      chk_frame("var8", 0, exp);
      clr();
      cfg_log2n = 2'd0;
      for (int i = 0; i < 8; i++) push(32'(70 + i));
      wait_outs("var0", 8);
      for (int i = 0; i < 8; i++) exp[i] = 32'(70 + ord[i]);
      chk_frame("var0", 0, exp);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
